// File: rtl/mux_n_pkg.sv
// Shared helpers for the N-channel round-robin mux: select-width sizing and
// pointer increment with wrap-around for non-power-of-two channel counts.
package mux_n_pkg;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational N-way arbiter: round-robin search starting at ptr, or a fixed
// index select where an out-of-range index simply produces no grant.
module rr_arbiter_n
    import mux_n_pkg::*;
#(
    parameter  int N  = 5,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          fixed_en,
    input  logic [SW-1:0] fixed_sel,
    output logic          grant_valid,
    output logic [SW-1:0] grant_idx
);

    logic          w_hi_valid;
    logic [SW-1:0] w_hi_idx;
    logic          w_lo_valid;
    logic [SW-1:0] w_lo_idx;

    // Descending scans leave the lowest matching index: the "hi" search covers
    // ptr..N-1, the "lo" search covers the whole vector and supplies the wrap.
    always_comb begin
        w_hi_valid = 1'b0;
        w_hi_idx   = '0;
        w_lo_valid = 1'b0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_valid = 1'b1;
                w_lo_idx   = SW'(i);
                if (i >= int'(ptr)) begin
                    w_hi_valid = 1'b1;
                    w_hi_idx   = SW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (fixed_en) begin
            for (int i = 0; i < N; i++) begin
                if (int'(fixed_sel) == i && req[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SW'(i);
                end
            end
        end else if (w_hi_valid) begin
            grant_valid = 1'b1;
            grant_idx   = w_hi_idx;
        end else if (w_lo_valid) begin
            grant_valid = 1'b1;
            grant_idx   = w_lo_idx;
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel valid/ready multiplexer with one registered output stage, sharing
// the output round-robin or by fixed index.
module rr_mux_n
    import mux_n_pkg::*;
#(
    parameter  int N  = 5,
    parameter  int W  = 8,
    localparam int SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           fixed_en,
    input  logic [SW-1:0]  fixed_sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
);

    logic [SW-1:0] r_ptr;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic [SW-1:0] r_out_sel;

    logic          w_load;
    logic          w_xfer;
    logic          w_grant_valid;
    logic [SW-1:0] w_grant_idx;
    logic [W-1:0]  w_grant_data;

    rr_arbiter_n #(.N(N)) u_arbiter (
        .req         (in_valid),
        .ptr         (r_ptr),
        .fixed_en    (fixed_en),
        .fixed_sel   (fixed_sel),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // Reset blocks acceptance so no producer sees a handshake for a word that
    // the register would immediately discard.
    assign w_load = !rst && (!r_out_valid || out_ready);
    assign w_xfer = w_load && w_grant_valid;

    always_comb begin
        in_ready     = '0;
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SW'(i)) begin
                in_ready[i]  = w_xfer;
                w_grant_data = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_grant_data;
            r_out_sel   <= w_grant_idx;
            r_out_valid <= 1'b1;
            if (!fixed_en) begin
                r_ptr <= SW'(wrap_inc(int'(w_grant_idx), N));
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: reset, round-robin fairness, backpressure,
// pointer wrap, fixed mode and an exhaustive fixed-select sweep.
module tb_rr_mux_n;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] inData;
    logic [N-1:0]   inValid;
    logic [N-1:0]   inReady;
    logic           fixedEn;
    logic [SW-1:0]  fixedSel;
    logic [W-1:0]   outData;
    logic           outValid;
    logic           outReady;
    logic [SW-1:0]  outSel;

    int checks   = 0;
    int failures = 0;

    rr_mux_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (inData),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .fixed_en  (fixedEn),
        .fixed_sel (fixedSel),
        .out_data  (outData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_sel   (outSel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] seqData(input logic [W-1:0] base);
        logic [N*W-1:0] d;
        d = '0;
        for (int i = 0; i < N; i++) d[i*W +: W] = base + W'(i);
        return d;
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        inValid  = 5'b11111;
        inData   = 40'hDE_AD_BE_EF_55;
        outReady = 1'b1;
        fixedEn  = 1'b0;
        fixedSel = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid c%0d: got %b want 0", c, outValid); end
            checks++;
            if (outData !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data c%0d: got %h want 00", c, outData); end
            checks++;
            if (outSel !== 3'd0) begin failures++; $display("[TB] FAIL reset_out_sel c%0d: got %0d want 0", c, outSel); end
            checks++;
            if (inReady !== 5'b00000) begin failures++; $display("[TB] FAIL reset_in_ready c%0d: got %b want 00000", c, inReady); end
        end
        rst     = 1'b0;
        inValid = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [SW-1:0] expSel;
        logic [N-1:0]  expReady;
        inData   = seqData(8'hA0);
        inValid  = 5'b11111;
        outReady = 1'b1;
        fixedEn  = 1'b0;
        #1;
        checks++;
        if (inReady !== 5'b00001) begin failures++; $display("[TB] FAIL fair_first_ready: got %b want 00001", inReady); end
        for (int k = 0; k < 7; k++) begin
            tick();
            expSel   = SW'(k % 5);
            expReady = N'(1) << ((k + 1) % 5);
            checks++;
            if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL fair_valid k%0d: got %b want 1", k, outValid); end
            checks++;
            if (outSel !== expSel) begin failures++; $display("[TB] FAIL fair_sel k%0d: got %0d want %0d", k, outSel, expSel); end
            checks++;
            if (outData !== 8'hA0 + W'(expSel)) begin failures++; $display("[TB] FAIL fair_data k%0d: got %h want %h", k, outData, 8'hA0 + W'(expSel)); end
            checks++;
            if (inReady !== expReady) begin failures++; $display("[TB] FAIL fair_ready k%0d: got %b want %b", k, inReady, expReady); end
        end
        inValid = '0;
        tick();
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL drain_valid: got %b want 0", outValid); end
        checks++;
        if (outData !== 8'hA1 || outSel !== 3'd1) begin failures++; $display("[TB] FAIL drain_hold: got %h/%0d want a1/1", outData, outSel); end
    endtask

    task automatic test_fixed();
        inData   = seqData(8'hA0);
        inValid  = 5'b11111;
        fixedEn  = 1'b1;
        fixedSel = 3'd3;
        outReady = 1'b1;
        #1;
        checks++;
        if (inReady !== 5'b01000) begin failures++; $display("[TB] FAIL fixed_first_ready: got %b want 01000", inReady); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (outValid !== 1'b1 || outSel !== 3'd3 || outData !== 8'hA3) begin
                failures++; $display("[TB] FAIL fixed_word k%0d: got v%b sel%0d %h want v1 sel3 a3", k, outValid, outSel, outData);
            end
            checks++;
            if (inReady !== 5'b01000) begin failures++; $display("[TB] FAIL fixed_ready k%0d: got %b want 01000", k, inReady); end
        end
        fixedSel = 3'd6;
        #1;
        checks++;
        if (inReady !== 5'b00000) begin failures++; $display("[TB] FAIL fixed_oor_ready: got %b want 00000", inReady); end
        checks++;
        if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL fixed_oor_held: got %b want 1", outValid); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (outValid !== 1'b0 || inReady !== 5'b00000) begin
                failures++; $display("[TB] FAIL fixed_oor_drain k%0d: got v%b rdy%b want v0 rdy00000", k, outValid, inReady);
            end
        end
        fixedEn = 1'b0;
        #1;
        checks++;
        if (inReady !== 5'b00100) begin failures++; $display("[TB] FAIL ptr_retained_ready: got %b want 00100", inReady); end
        tick();
        checks++;
        if (outSel !== 3'd2 || outData !== 8'hA2) begin failures++; $display("[TB] FAIL ptr_retained_word: got %0d/%h want 2/a2", outSel, outData); end
        inValid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        inData        = '0;
        inData[2*W +: W] = 8'h5C;
        inValid       = 5'b00100;
        outReady      = 1'b0;
        #1;
        checks++;
        if (inReady !== 5'b00100) begin failures++; $display("[TB] FAIL bp_first_ready: got %b want 00100", inReady); end
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (outValid !== 1'b1 || outData !== 8'h5C || outSel !== 3'd2) begin
                failures++; $display("[TB] FAIL bp_hold c%0d: got v%b %h sel%0d want v1 5c sel2", c, outValid, outData, outSel);
            end
            checks++;
            if (inReady !== 5'b00000) begin failures++; $display("[TB] FAIL bp_hold_ready c%0d: got %b want 00000", c, inReady); end
            tick();
        end
        outReady = 1'b1;
        #1;
        checks++;
        if (inReady !== 5'b00100) begin failures++; $display("[TB] FAIL bp_release_ready: got %b want 00100", inReady); end
        tick();
        checks++;
        if (outValid !== 1'b1 || outData !== 8'h5C) begin failures++; $display("[TB] FAIL bp_no_bubble: got v%b %h want v1 5c", outValid, outData); end
        inValid = '0;
        tick();
        checks++;
        if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain: got %b want 0", outValid); end
    endtask

    task automatic test_wrap();
        inData         = '0;
        inData[0 +: W] = 8'h10;
        inData[4*W +: W] = 8'h44;
        inValid        = 5'b00001;
        outReady       = 1'b0;
        tick();
        rst     = 1'b1;
        inValid = '0;
        tick();
        checks++;
        if (outValid !== 1'b0 || outData !== 8'h00 || outSel !== 3'd0) begin
            failures++; $display("[TB] FAIL midreset: got v%b %h sel%0d want v0 00 sel0", outValid, outData, outSel);
        end
        rst      = 1'b0;
        outReady = 1'b1;
        inValid  = 5'b10000;
        #1;
        checks++;
        if (inReady !== 5'b10000) begin failures++; $display("[TB] FAIL wrap_ready4: got %b want 10000", inReady); end
        tick();
        checks++;
        if (outSel !== 3'd4 || outData !== 8'h44) begin failures++; $display("[TB] FAIL wrap_word4: got %0d/%h want 4/44", outSel, outData); end
        inValid = 5'b10001;
        #1;
        checks++;
        if (inReady !== 5'b00001) begin failures++; $display("[TB] FAIL wrap_ready0: got %b want 00001", inReady); end
        tick();
        checks++;
        if (outSel !== 3'd0 || outData !== 8'h10) begin failures++; $display("[TB] FAIL wrap_word0: got %0d/%h want 0/10", outSel, outData); end
        checks++;
        if (inReady !== 5'b10000) begin failures++; $display("[TB] FAIL wrap_ready_next: got %b want 10000", inReady); end
        tick();
        checks++;
        if (outSel !== 3'd4 || outData !== 8'h44) begin failures++; $display("[TB] FAIL wrap_word_last: got %0d/%h want 4/44", outSel, outData); end
        inValid = '0;
        tick();
    endtask

    task automatic test_exhaustive();
        logic [N-1:0] vv;
        logic         expAcc;
        logic [N-1:0] expReady;
        inData   = seqData(8'hA0);
        outReady = 1'b1;
        fixedEn  = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int v = 0; v < 32; v++) begin
                vv       = N'(v);
                fixedSel = SW'(s);
                inValid  = vv;
                expAcc   = (s < N) ? vv[s] : 1'b0;
                expReady = expAcc ? (N'(1) << s) : '0;
                #1;
                checks++;
                if (inReady !== expReady) begin failures++; $display("[TB] FAIL sweep_ready s%0d v%b: got %b want %b", s, vv, inReady, expReady); end
                tick();
                checks++;
                if (outValid !== expAcc) begin failures++; $display("[TB] FAIL sweep_valid s%0d v%b: got %b want %b", s, vv, outValid, expAcc); end
                if (expAcc) begin
                    checks++;
                    if (outSel !== SW'(s) || outData !== 8'hA0 + W'(s)) begin
                        failures++; $display("[TB] FAIL sweep_word s%0d v%b: got %0d/%h want %0d/%h", s, vv, outSel, outData, s, 8'hA0 + W'(s));
                    end
                end
            end
        end
        fixedEn = 1'b0;
        inValid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_fixed();
        test_backpressure();
        test_wrap();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
